// File: rtl/fetch_decode_pipe.sv
// Y86-64 fetch-side PC register plus the F/D pipeline register.
// Selects the fetch PC, predicts the next one, derives fetch status and latches decode fields.
module fetch_decode_pipe #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [3:0]  RNONE    = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] f_pc,
    input  logic [3:0]  f_icode,
    input  logic [3:0]  f_ifun,
    input  logic [3:0]  f_rA,
    input  logic [3:0]  f_rB,
    input  logic [63:0] f_valC,
    input  logic [63:0] f_valP,
    input  logic        f_imem_error,
    input  logic        f_instr_valid,
    input  logic [3:0]  M_icode,
    input  logic        M_Cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valM,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    output logic [63:0] F_predPC,
    output logic [2:0]  f_stat,
    output logic [2:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP
);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] I_HALT = 4'h0;
    localparam logic [3:0] I_NOP  = 4'h1;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valC;
        logic [63:0] valP;
    } d_reg_t;

    localparam d_reg_t D_NOP = '{
        stat:  STAT_AOK,
        icode: I_NOP,
        ifun:  4'h0,
        rA:    RNONE,
        rB:    RNONE,
        valC:  64'h0,
        valP:  64'h0
    };

    logic [63:0] pred_pc;
    d_reg_t      d_next;
    d_reg_t      d_q;

    // Mispredicted branch recovery outranks ret return-address pickup.
    always_comb begin
        f_pc = F_predPC;
        if (M_icode == I_JXX && !M_Cnd)
            f_pc = M_valA;
        else if (W_icode == I_RET)
            f_pc = W_valM;
    end

    always_comb begin
        pred_pc = f_valP;
        if (f_icode == I_JXX || f_icode == I_CALL)
            pred_pc = f_valC;
    end

    always_comb begin
        f_stat = STAT_AOK;
        if (f_imem_error)
            f_stat = STAT_ADR;
        else if (!f_instr_valid)
            f_stat = STAT_INS;
        else if (f_icode == I_HALT)
            f_stat = STAT_HLT;
    end

    always_comb begin
        d_next       = D_NOP;
        d_next.stat  = f_stat;
        d_next.icode = f_icode;
        d_next.ifun  = f_ifun;
        d_next.rA    = f_rA;
        d_next.rB    = f_rB;
        d_next.valC  = f_valC;
        d_next.valP  = f_valP;
    end

    always_ff @(posedge clk) begin
        if (reset)
            F_predPC <= RESET_PC;
        else if (!F_stall)
            F_predPC <= pred_pc;
    end

    // Stall outranks bubble so a held instruction is never squashed.
    always_ff @(posedge clk) begin
        if (reset)
            d_q <= D_NOP;
        else if (!D_stall) begin
            if (D_bubble)
                d_q <= D_NOP;
            else
                d_q <= d_next;
        end
    end

    assign D_stat  = d_q.stat;
    assign D_icode = d_q.icode;
    assign D_ifun  = d_q.ifun;
    assign D_rA    = d_q.rA;
    assign D_rB    = d_q.rB;
    assign D_valC  = d_q.valC;
    assign D_valP  = d_q.valP;

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Scoreboard bench for fetch_decode_pipe: expected register state queued per clock,
// popped and compared just after each rising edge; combinational outputs checked inline.
module tb_fetch_decode_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] f_pc;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
    logic [63:0] f_valC, f_valP;
    logic        f_imem_error, f_instr_valid;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valA;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;
    logic        F_stall, D_stall, D_bubble;
    logic [63:0] F_predPC;
    logic [2:0]  f_stat, D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] pred;
        logic [2:0]  stat;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
    } exp_t;

    exp_t exp_q[$];

    fetch_decode_pipe dut (
        .clk(clk), .reset(reset), .f_pc(f_pc),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP),
        .f_imem_error(f_imem_error), .f_instr_valid(f_instr_valid),
        .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
        .W_icode(W_icode), .W_valM(W_valM),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .F_predPC(F_predPC), .f_stat(f_stat), .D_stat(D_stat),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    // Monitor: the register outputs are valid every cycle once a vector is queued.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("F_predPC", F_predPC, e.pred);
            chk("D_stat",   {61'd0, D_stat},  {61'd0, e.stat});
            chk("D_icode",  {60'd0, D_icode}, {60'd0, e.icode});
            chk("D_ifun",   {60'd0, D_ifun},  {60'd0, e.ifun});
            chk("D_rA",     {60'd0, D_rA},    {60'd0, e.ra});
            chk("D_rB",     {60'd0, D_rB},    {60'd0, e.rb});
            chk("D_valC",   D_valC, e.valc);
            chk("D_valP",   D_valP, e.valp);
        end
    end

    task automatic tick(input logic [63:0] pred, input logic [2:0] stat,
                        input logic [3:0] ic, input logic [3:0] ifn,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [63:0] vc, input logic [63:0] vp);
        exp_t e;
        e.pred = pred; e.stat = stat; e.icode = ic; e.ifun = ifn;
        e.ra = ra; e.rb = rb; e.valc = vc; e.valp = vp;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [3:0] ifn,
                         input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] vc, input logic [63:0] vp);
        f_icode = ic; f_ifun = ifn; f_rA = ra; f_rB = rb; f_valC = vc; f_valP = vp;
    endtask

    task automatic chk_comb(string name, logic [63:0] pc_req, logic [2:0] st_req);
        #1;
        chk({name, ".f_pc"}, f_pc, pc_req);
        chk({name, ".f_stat"}, {61'd0, f_stat}, {61'd0, st_req});
    endtask

    initial begin
        reset = 1'b1;
        fetch(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
        f_imem_error = 0; f_instr_valid = 1;
        M_icode = 0; M_Cnd = 0; M_valA = 0; W_icode = 0; W_valM = 0;
        F_stall = 0; D_stall = 0; D_bubble = 0;

        // Reset state
        tick(64'h0, 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
        reset = 1'b0;
        chk_comb("reset", 64'h0, 3'd1);

        // irmovq fall-through prediction
        fetch(4'h3, 4'h0, 4'hF, 4'h2, 64'h5, 64'd10);
        chk_comb("irmovq", 64'h0, 3'd1);
        tick(64'd10, 3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'h5, 64'd10);
        chk_comb("irmovq2", 64'd10, 3'd1);
        fetch(4'h3, 4'h0, 4'hF, 4'h2, 64'h5, 64'd12);
        tick(64'd12, 3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'h5, 64'd12);

        // jXX predicted taken, then mispredict recovery and select priority
        fetch(4'h7, 4'h1, 4'hF, 4'hF, 64'h40, 64'h15);
        tick(64'h40, 3'd1, 4'h7, 4'h1, 4'hF, 4'hF, 64'h40, 64'h15);
        chk_comb("jxx_pred", 64'h40, 3'd1);
        M_icode = 4'h7; M_Cnd = 0; M_valA = 64'h15;
        chk_comb("mispred", 64'h15, 3'd1);
        W_icode = 4'h9; W_valM = 64'h100;
        chk_comb("mispred_vs_ret", 64'h15, 3'd1);
        M_Cnd = 1;
        chk_comb("taken_ret", 64'h100, 3'd1);
        M_icode = 4'h1;
        chk_comb("ret", 64'h100, 3'd1);
        chk("ret.F_predPC_hold", F_predPC, 64'h40);
        fetch(4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h102);
        tick(64'h102, 3'd1, 4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h102);
        M_icode = 0; M_Cnd = 0; W_icode = 0;
        chk_comb("opq", 64'h102, 3'd1);

        // Stall beats bubble; bubble alone inserts a nop; F_stall independent of D
        F_stall = 1; D_stall = 1; D_bubble = 1;
        fetch(4'h2, 4'h0, 4'h3, 4'h4, 64'h0, 64'h200);
        tick(64'h102, 3'd1, 4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h102);
        F_stall = 0; D_stall = 0;
        tick(64'h200, 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
        F_stall = 1; D_bubble = 0;
        tick(64'h200, 3'd1, 4'h2, 4'h0, 4'h3, 4'h4, 64'h0, 64'h200);
        F_stall = 0;

        // Status priority; faulting instructions still flow into D
        f_imem_error = 1; f_instr_valid = 0;
        fetch(4'h2, 4'h0, 4'h3, 4'h4, 64'h0, 64'h202);
        chk_comb("adr", 64'h200, 3'd3);
        tick(64'h202, 3'd3, 4'h2, 4'h0, 4'h3, 4'h4, 64'h0, 64'h202);
        f_imem_error = 0;
        fetch(4'hC, 4'h0, 4'h3, 4'h4, 64'h0, 64'h204);
        chk_comb("ins", 64'h202, 3'd4);
        tick(64'h204, 3'd4, 4'hC, 4'h0, 4'h3, 4'h4, 64'h0, 64'h204);
        fetch(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h205);
        chk_comb("ins_vs_hlt", 64'h204, 3'd4);
        f_instr_valid = 1;
        chk_comb("hlt", 64'h204, 3'd2);
        tick(64'h205, 3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h205);

        // call predicts valC
        fetch(4'h8, 4'h0, 4'hF, 4'hF, 64'h300, 64'h20E);
        tick(64'h300, 3'd1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h300, 64'h20E);

        // Reset overrides a simultaneous stall and bubble
        F_stall = 1; D_stall = 1; D_bubble = 1; reset = 1;
        tick(64'h0, 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
        reset = 0; F_stall = 0; D_stall = 0; D_bubble = 0;

        // No width change at the top of the address space
        fetch(4'h3, 4'h0, 4'hF, 4'h1, 64'h7, 64'hFFFF_FFFF_FFFF_FFFF);
        tick(64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 4'h3, 4'h0, 4'hF, 4'h1, 64'h7, 64'hFFFF_FFFF_FFFF_FFFF);
        chk_comb("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 3'd1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
